// File: rtl/mio_bridge_pkg.sv
// Shared state encoding and address/error defaults for the CPU memory/IO bridge.
package mio_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM,
        ST_PER,
        ST_DONE,
        ST_TURN
    } state_t;

    localparam logic [3:0]  PER_BASE_DEF = 4'hE;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    function automatic logic is_per_space(input logic [31:0] a, input logic [3:0] base);
        return a[31:28] >= base;
    endfunction

endpackage

// File: rtl/mio_bridge.sv
// Routes one CPU access at a time to a fixed-latency RAM or a req/ack peripheral; RAM completes in RAM_LAT+1 cycles.
// The CPU stalls on MIO_ready; peripheral waits are bounded by PER_TO, after which the access completes with an error.
module mio_bridge
    import mio_bridge_pkg::*;
#(
    parameter int          RAM_LAT  = 2,
    parameter int          PER_TO   = 16,
    parameter logic [3:0]  PER_BASE = PER_BASE_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        CPU_MIO,
    input  logic [31:0] addr,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic [29:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        per_req,
    output logic        per_we,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    input  logic [31:0] per_rdata,
    input  logic        per_ack,
    output logic        bus_err
);

    localparam int CNT_MAX = (RAM_LAT > PER_TO) ? RAM_LAT : PER_TO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RAM_LAST = CW'(RAM_LAT);
    localparam logic [CW-1:0] PER_LAST = CW'(PER_TO);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_l      <= 1'b0;
            Data_in   <= '0;
            MIO_ready <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
            per_req   <= 1'b0;
            per_we    <= 1'b0;
            per_addr  <= '0;
            per_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            MIO_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CPU_MIO && (MemRead || MemWrite)) begin
                        // A simultaneous read+write is serviced as a write and flagged.
                        wr_l <= MemWrite;
                        cnt  <= CW'(1);
                        if (MemRead && MemWrite)
                            bus_err <= 1'b1;
                        if (is_per_space(addr, PER_BASE)) begin
                            per_req   <= 1'b1;
                            per_we    <= MemWrite;
                            per_addr  <= addr;
                            per_wdata <= Data_out;
                            state     <= ST_PER;
                        end else begin
                            ram_addr <= addr[31:2];
                            ram_din  <= Data_out;
                            ram_we   <= MemWrite;
                            state    <= ST_RAM;
                        end
                    end
                end
                ST_RAM: begin
                    if (cnt >= RAM_LAST) begin
                        if (!wr_l)
                            Data_in <= ram_dout;
                        MIO_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
                    end
                end
                ST_PER: begin
                    // An ack landing on the timeout cycle takes priority over the error.
                    if (per_ack) begin
                        if (!wr_l)
                            Data_in <= per_rdata;
                        per_req   <= 1'b0;
                        per_we    <= 1'b0;
                        MIO_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else if (cnt >= PER_LAST) begin
                        if (!wr_l)
                            Data_in <= ERR_DATA;
                        bus_err   <= 1'b1;
                        per_req   <= 1'b0;
                        per_we    <= 1'b0;
                        MIO_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
                    end
                end
                ST_DONE: state <= ST_TURN;
                // The controller may still be driving its strobes here.
                ST_TURN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bridge.sv
// Randomized scoreboard bench for mio_bridge with a behavioural RAM, peripheral responder and access model.
module tb_mio_bridge;

    localparam int RAM_LAT = 2;
    localparam int PER_TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [31:0] addr, Data_out, Data_in;
    logic        MIO_ready;
    logic [29:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din, ram_dout;
    logic        per_req, per_we;
    logic [31:0] per_addr, per_wdata, per_rdata;
    logic        per_ack;
    logic        bus_err;

    mio_bridge #(.RAM_LAT(RAM_LAT), .PER_TO(PER_TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .addr(addr), .Data_out(Data_out), .Data_in(Data_in), .MIO_ready(MIO_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_rdata(per_rdata), .per_ack(per_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 64-word RAM, aliased on word address bits [5:0]; unwritten words read a fixed pattern.
    function automatic logic [31:0] ram_init(input logic [5:0] i);
        return (i == 6'd4) ? 32'h1234_5678 : {16'hC0DE, 10'd0, i};
    endfunction

    logic [31:0] ram_dev [0:63];
    logic [63:0] ram_vld = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            ram_dev[ram_addr[5:0]] <= ram_din;
            ram_vld[ram_addr[5:0]] <= 1'b1;
        end
    end
    always_comb begin
        ram_dout = ram_vld[ram_addr[5:0]] ? ram_dev[ram_addr[5:0]] : ram_init(ram_addr[5:0]);
    end

    // Peripheral: acks in the ack_dly-th cycle of a request (0 = never), random stray acks when idle.
    int          ack_dly;
    int          req_len;
    logic        req_prev, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    initial begin
        per_ack = 1'b0; per_rdata = '0; req_len = 0; req_prev = 1'b0;
        cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (per_req) begin
                if (!req_prev) begin
                    req_len = 1; cap_we = per_we; cap_addr = per_addr; cap_wdata = per_wdata;
                end else begin
                    req_len++;
                end
                if (ack_dly != 0 && req_len == ack_dly) begin
                    per_ack = 1'b1; per_rdata = per_addr ^ 32'h5A5A_A5A5;
                end else begin
                    per_ack = 1'b0; per_rdata = $urandom;
                end
            end else begin
                per_ack = ($urandom_range(0, 7) == 0); per_rdata = $urandom;
            end
            req_prev = per_req;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        logic        per;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          req_len;
        int          ram_we_cnt;
        int          start;
    } exp_t;

    exp_t        q[$];
    int          rst_req = 0;
    logic        fin = 1'b0;

    // Access model: word memory, last read value, sticky error.
    logic [31:0] mem_m [0:63];
    logic [31:0] last_rd;
    logic        err_m;

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int dly, input int hold);
        exp_t e;
        logic to, done;
        e.per = (a[31:28] >= 4'hE);
        e.we = wr; e.addr = a; e.wdata = d;
        e.req_len = 0; e.ram_we_cnt = 0;
        if (rd && wr) err_m = 1'b1;
        if (e.per) begin
            to = (dly == 0) || (dly > PER_TO);
            e.lat = to ? PER_TO + 1 : dly + 1;
            e.req_len = to ? PER_TO : dly;
            if (to) err_m = 1'b1;
            if (!wr) last_rd = to ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
        end else begin
            e.lat = RAM_LAT + 1;
            if (wr) begin
                mem_m[a[7:2]] = d;
                e.ram_we_cnt = 1;
            end else begin
                last_rd = mem_m[a[7:2]];
            end
        end
        e.data = last_rd; e.err = err_m;
        @(posedge clk); #1;
        ack_dly = dly;
        MemRead = rd; MemWrite = wr; CPU_MIO = 1'b1; addr = a; Data_out = d;
        e.start = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        addr = $urandom; Data_out = $urandom;
        done = MIO_ready;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (MIO_ready) done = 1'b1;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
    endtask

    task automatic gap_noise(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemRead = 1'($urandom); MemWrite = 1'($urandom); CPU_MIO = 1'b0; addr = $urandom;
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_req++;
        last_rd = '0; err_m = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Stimulus
    initial begin
        logic [31:0] a;
        logic        rd, wr;
        int          k, r;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        addr = '0; Data_out = '0; ack_dly = 0;
        for (int i = 0; i < 64; i++) mem_m[i] = ram_init(6'(i));
        last_rd = '0; err_m = 1'b0;
        apply_reset(3);

        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 0);
        run_txn(1'b0, 1'b1, 32'hE000_0000, 32'hA5A5_A5A5, 4, 1);
        run_txn(1'b1, 1'b0, 32'hE000_0100, 32'h0, 0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 1);
        run_txn(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 0);
        run_txn(1'b1, 1'b0, 32'hF000_0008, 32'h0, PER_TO, 0);
        run_txn(1'b0, 1'b1, 32'hF000_000C, 32'h1111_2222, 1, 0);

        // Abort a peripheral read mid-wait.
        @(posedge clk); #1;
        ack_dly = 0;
        MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'hF000_0040;
        repeat (5) @(posedge clk);
        #1;
        apply_reset(1);
        gap_noise(2);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            rd = (k == 0) || (k < 5);
            wr = (k == 0) || (k >= 5);
            if ($urandom_range(0, 1) == 1)
                a = {4'($urandom_range(14, 15)), 28'($urandom)};
            else
                a = {4'($urandom_range(0, 13)), 28'($urandom)};
            r = $urandom_range(0, 19);
            gap_noise($urandom_range(0, 2));
            run_txn(rd, wr, a, $urandom, (r < 3) ? 0 : r - 2, $urandom_range(0, 1));
        end
        repeat (5) @(posedge clk);
        fin = 1'b1;
    end

    // Monitor / scoreboard
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        int   rst_seen = 0;
        int   we_cnt = 0;
        logic rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fin) begin
                chk("queue_empty", 32'(q.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("rst_Data_in", Data_in, 32'd0);
                chk("rst_MIO_ready", 32'(MIO_ready), 32'd0);
                chk("rst_per_req", 32'(per_req), 32'd0);
                chk("rst_per_we", 32'(per_we), 32'd0);
                chk("rst_ram_we", 32'(ram_we), 32'd0);
                chk("rst_bus_err", 32'(bus_err), 32'd0);
                chk("rst_ram_addr", 32'(ram_addr), 32'd0);
                chk("rst_per_addr", per_addr, 32'd0);
                we_cnt = 0;
            end
            if (ram_we) we_cnt++;
            if (rdy_prev) chk("ready_one_cycle", 32'(MIO_ready), 32'd0);
            if (MIO_ready && !rdy_prev) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_ready: got MIO_ready with no access pending (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("Data_in", Data_in, e.data);
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.start), 32'(e.lat));
                    if (e.per) begin
                        chk("per_req_cycles", 32'(req_len), 32'(e.req_len));
                        chk("per_we", 32'(cap_we), 32'(e.we));
                        chk("per_addr", cap_addr, e.addr);
                        chk("per_wdata", cap_wdata, e.wdata);
                        chk("ram_we_count", 32'(we_cnt), 32'd0);
                    end else begin
                        chk("ram_addr", 32'(ram_addr), 32'(e.addr[31:2]));
                        chk("ram_we_count", 32'(we_cnt), 32'(e.ram_we_cnt));
                    end
                    we_cnt = 0;
                end
            end
            if (q.size() > 0 && (cyc - q[0].start) > 60) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: no MIO_ready after 60 cycles, required one (start %0d)", q[0].start);
                e = q.pop_front();
            end
            rdy_prev = MIO_ready;
        end
    end

endmodule
